// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared types and constants for the 4x4 keypad scanner.
//   fsm_state_e  : scanner FSM states (SCAN, DEBOUNCE, HOLD)
//   ROWS_IDLE    : row pattern with no key pressed (rows pulled up)
//   COL_RESET    : column drive right after reset (column 0 driven low)
//   ENTRY_W      : width of the entry register
//   MAX_DIGITS   : saturation value of the digit counter
// Helper functions classify a synchronized row sample.
// -----------------------------------------------------------------------------
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2
    } fsm_state_e;

    localparam logic [3:0] ROWS_IDLE  = 4'b1111;
    localparam logic [3:0] COL_RESET  = 4'b1110;
    localparam int         ENTRY_W    = 32;
    localparam logic [3:0] MAX_DIGITS = 4'd8;

    // True when exactly one row line is pulled low.
    function automatic logic one_row_low(input logic [3:0] r);
        return (r == 4'b1110) || (r == 4'b1101) ||
               (r == 4'b1011) || (r == 4'b0111);
    endfunction

    // Index of the low row line; only meaningful when one_row_low(r) is true.
    function automatic logic [1:0] low_row_index(input logic [3:0] r);
        logic [1:0] idx;
        idx = 2'd0;
        case (r)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// -----------------------------------------------------------------------------
// keypad_scanner_if
// Bundles the keypad pins, the key-event outputs and the entry register.
//   row         : keypad rows, active-low, asynchronous to clk
//   clear       : synchronous clear of the entry register
//   col         : column drive, active-low, exactly one bit low
//   key_code    : code of the last accepted key (row_idx*4 + col_idx)
//   key_valid   : one-clk pulse per accepted press
//   entry_value : shifted-in hex digits, newest in [3:0]
//   digit_count : digits entered, saturating at 8
//   dbg_state   : current scanner FSM state (observation only)
//   dbg_tick    : scan tick strobe (observation only)
// Modports: master = scanner side, slave = pins/consumer side.
// Handshake: key_valid is a pure event strobe with no ready/backpressure;
// key_code is valid in the key_valid cycle and holds until the next event.
// -----------------------------------------------------------------------------
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic [3:0]         row;
    logic               clear;
    logic [3:0]         col;
    logic [3:0]         key_code;
    logic               key_valid;
    logic [ENTRY_W-1:0] entry_value;
    logic [3:0]         digit_count;
    fsm_state_e         dbg_state;
    logic               dbg_tick;

    modport master (
        input  row, clear,
        output col, key_code, key_valid, entry_value, digit_count,
               dbg_state, dbg_tick
    );

    modport slave (
        output row, clear,
        input  col, key_code, key_valid, entry_value, digit_count,
               dbg_state, dbg_tick
    );

endinterface

// File: rtl/scan_tick_gen.sv
// -----------------------------------------------------------------------------
// scan_tick_gen
// Free-running divider: counts 0..SCAN_DIV-1 and wraps; tick_o is high for
// the single clk in which the counter holds SCAN_DIV-1.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset (counter to 0)
//   tick_o : one-clk strobe every SCAN_DIV cycles
// -----------------------------------------------------------------------------
module scan_tick_gen #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// 4x4 matrix keypad front-end. Drives one column low at a time, samples the
// synchronized rows on each scan tick, debounces press and release, emits a
// one-clk key event with a hex code, and shifts accepted digits into a
// 32-bit entry register.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   kp    : keypad_scanner_if.master (row/clear in; col, key event, entry,
//           debug state/tick out)
// Parameters:
//   SCAN_DIV       : clk cycles per scan tick (>= 2)
//   DEBOUNCE_TICKS : identical tick samples needed for press/release (>= 1)
// -----------------------------------------------------------------------------
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    keypad_scanner_if.master  kp
);

    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_TICKS);

    logic                tick;
    logic [3:0]          rs_meta_q;
    logic [3:0]          rs_q;

    fsm_state_e          state_q, state_d;
    logic [1:0]          col_idx_q, col_idx_d;
    logic [1:0]          row_idx_q, row_idx_d;
    logic [3:0]          pat_q, pat_d;
    logic [DW-1:0]       cnt_q, cnt_d;
    logic [DW-1:0]       cnt_inc;
    logic                accept;

    logic                key_valid_q;
    logic [3:0]          key_code_q;
    logic [ENTRY_W-1:0]  entry_q;
    logic [3:0]          digits_q;

    scan_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (tick)
    );

    // Two-flop synchronizer; reset to idle so no phantom press after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_meta_q <= ROWS_IDLE;
            rs_q      <= ROWS_IDLE;
        end else begin
            rs_meta_q <= kp.row;
            rs_q      <= rs_meta_q;
        end
    end

    assign cnt_inc = cnt_q + DW'(1);

    // Next-state logic: everything moves only on tick cycles.
    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        row_idx_d = row_idx_q;
        pat_d     = pat_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (rs_q == ROWS_IDLE) begin
                        col_idx_d = col_idx_q + 2'd1;
                    end else if (one_row_low(rs_q)) begin
                        pat_d     = rs_q;
                        row_idx_d = low_row_index(rs_q);
                        if (DEBOUNCE_TICKS == 1) begin
                            accept  = 1'b1;
                            cnt_d   = '0;
                            state_d = HOLD;
                        end else begin
                            cnt_d   = DW'(1);
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        // Two or more rows low: ghosting / multi-key, skip column.
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (rs_q == pat_q) begin
                        if (cnt_inc == DB_LAST) begin
                            accept  = 1'b1;
                            cnt_d   = '0;
                            state_d = HOLD;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = SCAN;
                    end
                end
                HOLD: begin
                    // Count now tracks consecutive idle samples (release).
                    if (rs_q == ROWS_IDLE) begin
                        if (cnt_inc == DB_LAST) begin
                            cnt_d     = '0;
                            col_idx_d = col_idx_q + 2'd1;
                            state_d   = SCAN;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = SCAN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SCAN;
            col_idx_q <= 2'd0;
            row_idx_q <= 2'd0;
            pat_q     <= ROWS_IDLE;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            row_idx_q <= row_idx_d;
            pat_q     <= pat_d;
            cnt_q     <= cnt_d;
        end
    end

    // Key event: registered one clk after the accepting tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_valid_q <= 1'b0;
            key_code_q  <= 4'd0;
        end else begin
            key_valid_q <= accept;
            if (accept) begin
                key_code_q <= {row_idx_d, col_idx_d};
            end
        end
    end

    // Entry register updates at the edge that closes the key_valid cycle;
    // clear takes priority over a coincident key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q  <= '0;
            digits_q <= 4'd0;
        end else if (kp.clear) begin
            entry_q  <= '0;
            digits_q <= 4'd0;
        end else if (key_valid_q) begin
            entry_q  <= {entry_q[ENTRY_W-5:0], key_code_q};
            digits_q <= (digits_q == MAX_DIGITS) ? MAX_DIGITS : digits_q + 4'd1;
        end
    end

    assign kp.col         = ~(4'b0001 << col_idx_q);
    assign kp.key_code    = key_code_q;
    assign kp.key_valid   = key_valid_q;
    assign kp.entry_value = entry_q;
    assign kp.digit_count = digits_q;
    assign kp.dbg_state   = state_q;
    assign kp.dbg_tick    = tick;

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;
    import keypad_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    // Keypad model: rows in key_mask are pulled low while column key_c is driven.
    logic [3:0] key_mask;
    logic [1:0] key_c;
    int         valid_cnt;
    bit         nonscan_seen;

    keypad_scanner_if kp ();

    keypad_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_TICKS (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kp    (kp)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        kp.row = 4'b1111;
        if (kp.col[key_c] == 1'b0) begin
            kp.row = ~key_mask;
        end
    end

    always @(negedge clk) begin
        if (kp.key_valid === 1'b1) valid_cnt = valid_cnt + 1;
        if (kp.dbg_state !== SCAN) nonscan_seen = 1'b1;
    end

    // Driver tasks
    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (kp.dbg_tick === 1'b1) begin
                @(negedge clk);
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic clear_pulse();
        @(negedge clk);
        kp.clear = 1'b1;
        @(negedge clk);
        kp.clear = 1'b0;
    endtask

    // Press a key, wait for its event, release it and wait for SCAN again.
    task automatic press_key(input logic [3:0] code, input bit clr_on_valid,
                             output int lat);
        bit seen_db;
        bit got;
        bit back;
        int n;
        seen_db  = 1'b0;
        got      = 1'b0;
        back     = 1'b0;
        n        = 0;
        lat      = -1;
        key_c    = code[1:0];
        key_mask = 4'b0001 << code[3:2];
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (!seen_db && kp.dbg_state === DEBOUNCE) begin
                seen_db = 1'b1;
                n = 0;
            end else if (seen_db) begin
                n++;
            end
            if (kp.key_valid === 1'b1) begin
                got = 1'b1;
                lat = n;
                if (clr_on_valid) kp.clear = 1'b1;
            end
        end
        if (clr_on_valid) begin
            @(negedge clk);
            kp.clear = 1'b0;
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL press_timeout code=%h: key_valid not seen, required within 400 cycles", code);
        end
        key_mask = 4'b0000;
        for (int i = 0; i < 200 && !back; i++) begin
            @(negedge clk);
            if (kp.dbg_state === SCAN) back = 1'b1;
        end
        n_checks++;
        if (!back) begin
            n_fail++;
            $display("FAIL release_timeout code=%h: state=%0d, required SCAN", code, kp.dbg_state);
        end
    endtask

    // Scenario tasks
    task automatic test_reset();
        rst_n    = 1'b0;
        kp.clear = 1'b0;
        key_mask = 4'b0000;
        key_c    = 2'd0;
        repeat (3) @(negedge clk);
        n_checks++; if (kp.col !== 4'b1110) begin n_fail++; $display("FAIL reset_col: got %b, required 1110", kp.col); end
        n_checks++; if (kp.key_code !== 4'h0) begin n_fail++; $display("FAIL reset_key_code: got %h, required 0", kp.key_code); end
        n_checks++; if (kp.key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_key_valid: got %b, required 0", kp.key_valid); end
        n_checks++; if (kp.entry_value !== 32'h0) begin n_fail++; $display("FAIL reset_entry: got %h, required 0", kp.entry_value); end
        n_checks++; if (kp.digit_count !== 4'd0) begin n_fail++; $display("FAIL reset_digits: got %0d, required 0", kp.digit_count); end
        n_checks++; if (kp.dbg_state !== SCAN) begin n_fail++; $display("FAIL reset_state: got %0d, required SCAN", kp.dbg_state); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_clean_press();
        int lat;
        valid_cnt = 0;
        press_key(4'h6, 1'b0, lat);
        n_checks++; if (valid_cnt !== 1) begin n_fail++; $display("FAIL clean_pulses: got %0d, required 1", valid_cnt); end
        n_checks++; if (kp.key_code !== 4'h6) begin n_fail++; $display("FAIL clean_code: got %h, required 6", kp.key_code); end
        n_checks++; if (kp.entry_value !== 32'h00000006) begin n_fail++; $display("FAIL clean_entry: got %h, required 00000006", kp.entry_value); end
        n_checks++; if (kp.digit_count !== 4'd1) begin n_fail++; $display("FAIL clean_digits: got %0d, required 1", kp.digit_count); end
        // Two more tick periods after the first press sample, then one clk.
        n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL clean_latency: got %0d, required 8", lat); end
    endtask

    task automatic test_bounce();
        bit ok;
        bit found;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            wait_tick(ok);
            if (kp.col === 4'b1011 && kp.dbg_state === SCAN) found = 1'b1;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL bounce_find_col: col=%b, required 1011 within 12 ticks", kp.col); end
        valid_cnt = 0;
        key_c = 2'd2;
        key_mask = 4'b0010;
        wait_tick(ok);
        n_checks++; if (kp.dbg_state !== DEBOUNCE) begin n_fail++; $display("FAIL bounce_enter_db: got %0d, required DEBOUNCE", kp.dbg_state); end
        key_mask = 4'b0000;
        wait_tick(ok);
        n_checks++; if (kp.dbg_state !== SCAN) begin n_fail++; $display("FAIL bounce_abort: got %0d, required SCAN", kp.dbg_state); end
        key_mask = 4'b0010;
        wait_tick(ok);
        key_mask = 4'b0000;
        wait_tick(ok);
        n_checks++; if (kp.dbg_state !== SCAN) begin n_fail++; $display("FAIL bounce_final_state: got %0d, required SCAN", kp.dbg_state); end
        n_checks++; if (kp.col !== 4'b1011) begin n_fail++; $display("FAIL bounce_col: got %b, required 1011", kp.col); end
        n_checks++; if (valid_cnt !== 0) begin n_fail++; $display("FAIL bounce_pulses: got %0d, required 0", valid_cnt); end
    endtask

    task automatic test_sequence();
        int lat;
        clear_pulse();
        press_key(4'h1, 1'b0, lat);
        press_key(4'h2, 1'b0, lat);
        press_key(4'h3, 1'b0, lat);
        press_key(4'hF, 1'b0, lat);
        n_checks++; if (kp.entry_value !== 32'h0000123F) begin n_fail++; $display("FAIL seq_entry: got %h, required 0000123F", kp.entry_value); end
        n_checks++; if (kp.digit_count !== 4'd4) begin n_fail++; $display("FAIL seq_digits: got %0d, required 4", kp.digit_count); end
    endtask

    task automatic test_overflow();
        int lat;
        logic [3:0] code;
        clear_pulse();
        for (int k = 1; k <= 9; k++) begin
            code = 4'(k);
            press_key(code, 1'b0, lat);
        end
        n_checks++; if (kp.entry_value !== 32'h23456789) begin n_fail++; $display("FAIL ovf_entry: got %h, required 23456789", kp.entry_value); end
        n_checks++; if (kp.digit_count !== 4'd8) begin n_fail++; $display("FAIL ovf_digits: got %0d, required 8", kp.digit_count); end
    endtask

    task automatic test_clear_vs_key();
        int lat;
        clear_pulse();
        press_key(4'h1, 1'b0, lat);
        press_key(4'h2, 1'b0, lat);
        n_checks++; if (kp.entry_value !== 32'h00000012) begin n_fail++; $display("FAIL clr_pre_entry: got %h, required 00000012", kp.entry_value); end
        press_key(4'h5, 1'b1, lat);
        n_checks++; if (kp.entry_value !== 32'h0) begin n_fail++; $display("FAIL clr_entry: got %h, required 0", kp.entry_value); end
        n_checks++; if (kp.digit_count !== 4'd0) begin n_fail++; $display("FAIL clr_digits: got %0d, required 0", kp.digit_count); end
        n_checks++; if (kp.key_code !== 4'h5) begin n_fail++; $display("FAIL clr_code: got %h, required 5", kp.key_code); end
    endtask

    task automatic test_reset_mid_hold();
        bit got;
        bit back;
        got = 1'b0;
        back = 1'b0;
        key_c = 2'd2;
        key_mask = 4'b0010;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (kp.key_valid === 1'b1) got = 1'b1;
        end
        repeat (6) @(negedge clk);
        n_checks++; if (kp.dbg_state !== HOLD) begin n_fail++; $display("FAIL rst_pre_hold: got %0d, required HOLD", kp.dbg_state); end
        rst_n = 1'b0;
        #2;
        n_checks++; if (kp.col !== 4'b1110) begin n_fail++; $display("FAIL rst_hold_col: got %b, required 1110", kp.col); end
        n_checks++; if (kp.key_code !== 4'h0) begin n_fail++; $display("FAIL rst_hold_code: got %h, required 0", kp.key_code); end
        n_checks++; if (kp.key_valid !== 1'b0) begin n_fail++; $display("FAIL rst_hold_valid: got %b, required 0", kp.key_valid); end
        n_checks++; if (kp.entry_value !== 32'h0) begin n_fail++; $display("FAIL rst_hold_entry: got %h, required 0", kp.entry_value); end
        n_checks++; if (kp.digit_count !== 4'd0) begin n_fail++; $display("FAIL rst_hold_digits: got %0d, required 0", kp.digit_count); end
        n_checks++; if (kp.dbg_state !== SCAN) begin n_fail++; $display("FAIL rst_hold_state: got %0d, required SCAN", kp.dbg_state); end
        @(negedge clk);
        valid_cnt = 0;
        rst_n = 1'b1;
        // Key stays held: expect one new accept, then no repeat while held.
        repeat (150) @(negedge clk);
        key_mask = 4'b0000;
        for (int i = 0; i < 200 && !back; i++) begin
            @(negedge clk);
            if (kp.dbg_state === SCAN) back = 1'b1;
        end
        n_checks++; if (valid_cnt !== 1) begin n_fail++; $display("FAIL rst_reaccept_pulses: got %0d, required 1", valid_cnt); end
        n_checks++; if (kp.key_code !== 4'h6) begin n_fail++; $display("FAIL rst_reaccept_code: got %h, required 6", kp.key_code); end
        n_checks++; if (kp.entry_value !== 32'h00000006) begin n_fail++; $display("FAIL rst_reaccept_entry: got %h, required 00000006", kp.entry_value); end
        n_checks++; if (kp.digit_count !== 4'd1) begin n_fail++; $display("FAIL rst_reaccept_digits: got %0d, required 1", kp.digit_count); end
    endtask

    task automatic test_multi_key();
        repeat (20) @(negedge clk);
        valid_cnt = 0;
        nonscan_seen = 1'b0;
        key_c = 2'd1;
        key_mask = 4'b0011;
        repeat (200) @(negedge clk);
        key_mask = 4'b0000;
        repeat (10) @(negedge clk);
        n_checks++; if (valid_cnt !== 0) begin n_fail++; $display("FAIL multi_pulses: got %0d, required 0", valid_cnt); end
        n_checks++; if (nonscan_seen !== 1'b0) begin n_fail++; $display("FAIL multi_state: left SCAN=%b, required 0", nonscan_seen); end
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        valid_cnt    = 0;
        nonscan_seen = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_sequence();
        test_overflow();
        test_clear_vs_key();
        test_reset_mid_hold();
        test_multi_key();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
